// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: scoreboard-based forwarding and load-use detection,
// branch redirect flushes, and data-memory wait freeze with timeout watchdog.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] ID_RS1,
  input  logic [4:0] ID_RS2,
  input  logic       ID_USE_RS1,
  input  logic       ID_USE_RS2,
  input  logic [4:0] ID_RD,
  input  logic       ID_REG_WRITE_EN,
  input  logic       ID_IS_LOAD,
  input  logic       PC_SEL,
  input  logic       DMEM_REQ,
  input  logic       DMEM_READY,
  output logic       STALL_F,
  output logic       STALL_D,
  output logic       STALL_E,
  output logic       STALL_M,
  output logic       FLUSH_D,
  output logic       FLUSH_E,
  output logic [1:0] FWD_A_SEL,
  output logic [1:0] FWD_B_SEL,
  output logic       MEM_ERR
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } ex_ent_t;

  // Only EX needs the load flag; a WB-stage producer is covered by the
  // write-through register file, so no WB entry is kept.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
  } mem_ent_t;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  ex_ent_t          ex_q;
  mem_ent_t         mem_q;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic ex_a, ex_b, mem_a, mem_b, load_use, frz;
  logic sf, sd, se, sm, fd, fe;

  always_comb begin
    ex_a  = ex_q.valid  && ex_q.we  && (ex_q.rd  == ID_RS1) && (ID_RS1 != 5'd0) && ID_USE_RS1;
    ex_b  = ex_q.valid  && ex_q.we  && (ex_q.rd  == ID_RS2) && (ID_RS2 != 5'd0) && ID_USE_RS2;
    mem_a = mem_q.valid && mem_q.we && (mem_q.rd == ID_RS1) && (ID_RS1 != 5'd0) && ID_USE_RS1;
    mem_b = mem_q.valid && mem_q.we && (mem_q.rd == ID_RS2) && (ID_RS2 != 5'd0) && ID_USE_RS2;
    load_use = ex_q.ld && (ex_a || ex_b);
  end

  always_comb begin
    FWD_A_SEL = 2'b00;
    FWD_B_SEL = 2'b00;
    if (ex_a && !ex_q.ld) FWD_A_SEL = 2'b01;
    else if (mem_a)       FWD_A_SEL = 2'b10;
    if (ex_b && !ex_q.ld) FWD_B_SEL = 2'b01;
    else if (mem_b)       FWD_B_SEL = 2'b10;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    frz       = 1'b0;
    case (state)
      RUN: begin
        if (DMEM_REQ && !DMEM_READY) begin
          frz       = 1'b1;
          state_nxt = MEM_WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        // Ready releases the freeze in the same cycle.
        if (DMEM_READY) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          frz = 1'b1;
          if (cnt == TMO) state_nxt = ERR;
          else            cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      ERR:     frz = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    sf = frz;
    sd = frz;
    se = frz;
    sm = frz;
    fd = 1'b0;
    fe = 1'b0;
    if (!frz) begin
      if (PC_SEL) begin
        fd = 1'b1;
        fe = 1'b1;
      end else if (load_use) begin
        sf = 1'b1;
        sd = 1'b1;
        fe = 1'b1;
      end
    end
  end

  // Memory inputs may be active during reset; keep every output quiet then.
  assign STALL_F = RST_N && sf;
  assign STALL_D = RST_N && sd;
  assign STALL_E = RST_N && se;
  assign STALL_M = RST_N && sm;
  assign FLUSH_D = RST_N && fd;
  assign FLUSH_E = RST_N && fe;
  assign MEM_ERR = (state == ERR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RUN;
      cnt   <= '0;
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!sm) begin
        mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, we: ex_q.we};
        if (fe) ex_q <= '0;
        else    ex_q <= '{valid: 1'b1, rd: ID_RD, we: ID_REG_WRITE_EN, ld: ID_IS_LOAD};
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: directed hazard scenarios with literal expectations plus
// randomized traffic compared every cycle against an in-flight instruction model.
module tb_hazard_control_unit;
  localparam int TMO = 4;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic [4:0] ID_RS1 = '0, ID_RS2 = '0, ID_RD = '0;
  logic       ID_USE_RS1 = 0, ID_USE_RS2 = 0, ID_REG_WRITE_EN = 0, ID_IS_LOAD = 0;
  logic       PC_SEL = 0, DMEM_REQ = 0, DMEM_READY = 0;
  logic       STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, MEM_ERR;
  logic [1:0] FWD_A_SEL, FWD_B_SEL;

  hazard_control_unit #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USE_RS1(ID_USE_RS1), .ID_USE_RS2(ID_USE_RS2),
    .ID_RD(ID_RD), .ID_REG_WRITE_EN(ID_REG_WRITE_EN), .ID_IS_LOAD(ID_IS_LOAD),
    .PC_SEL(PC_SEL), .DMEM_REQ(DMEM_REQ), .DMEM_READY(DMEM_READY),
    .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E), .STALL_M(STALL_M),
    .FLUSH_D(FLUSH_D), .FLUSH_E(FLUSH_E), .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .MEM_ERR(MEM_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: instructions in flight, youngest first (EX, MEM, WB), plus memory-wait bookkeeping.
  typedef struct {bit v; int rd; bit we; bit ld;} ins_t;
  ins_t pipe [3];
  bit   m_wait = 0, m_err = 0;
  int   m_waited = 0;
  bit   e_frz = 0, e_fe = 0;

  function automatic bit writes(input int k, input int rs, input bit u);
    return pipe[k].v && pipe[k].we && pipe[k].rd == rs && rs != 0 && u;
  endfunction

  function automatic logic [1:0] src(input int rs, input bit u);
    if (writes(0, rs, u) && !pipe[0].ld) return 2'b01;
    if (writes(1, rs, u)) return 2'b10;
    return 2'b00;
  endfunction

  always @(negedge CLK) begin
    bit frz, lu, sf, sd, fd, fe;
    lu  = pipe[0].ld && (writes(0, ID_RS1, ID_USE_RS1) || writes(0, ID_RS2, ID_USE_RS2));
    frz = m_err || (!DMEM_READY && (m_wait || DMEM_REQ));
    sf = frz; sd = frz; fd = 0; fe = 0;
    if (!frz && PC_SEL) begin fd = 1; fe = 1; end
    else if (!frz && lu) begin sf = 1; sd = 1; fe = 1; end
    if (!RST_N) begin frz = 0; sf = 0; sd = 0; fd = 0; fe = 0; end
    chk("ctl", {STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, MEM_ERR},
        {sf, sd, frz, frz, fd, fe, m_err});
    if (!lu) begin
      chk("fwd_a", FWD_A_SEL, src(ID_RS1, ID_USE_RS1));
      chk("fwd_b", FWD_B_SEL, src(ID_RS2, ID_USE_RS2));
    end
    e_frz <= frz;
    e_fe  <= fe;
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < 3; k++) pipe[k] <= '{0, 0, 0, 0};
      m_wait <= 0; m_err <= 0; m_waited <= 0;
    end else begin
      if (!e_frz) begin
        pipe[2] <= pipe[1];
        pipe[1] <= pipe[0];
        if (e_fe) pipe[0] <= '{0, 0, 0, 0};
        else      pipe[0] <= '{1, int'(ID_RD), ID_REG_WRITE_EN, ID_IS_LOAD};
      end
      if (m_err) ;
      else if (m_wait) begin
        if (DMEM_READY)           begin m_wait <= 0; m_waited <= 0; end
        else if (m_waited == TMO) m_err <= 1;
        else                      m_waited <= m_waited + 1;
      end else if (DMEM_REQ && !DMEM_READY) begin
        m_wait <= 1; m_waited <= 1;
      end
    end
  end

  task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input bit ld);
    ID_RS1 = 5'(rs1); ID_USE_RS1 = u1; ID_RS2 = 5'(rs2); ID_USE_RS2 = u2;
    ID_RD = 5'(rd); ID_REG_WRITE_EN = we; ID_IS_LOAD = ld;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  initial begin
    int n, cnt_st, lows;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_outs", {STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, FWD_A_SEL, FWD_B_SEL, MEM_ERR}, 0);
    step(); RST_N = 1;

    // Forwarding distance 1, 2, 3 and x0
    drain(); set_id(0, 0, 0, 0, 5, 1, 0); step();
    set_id(5, 1, 0, 0, 0, 0, 0); @(negedge CLK); chk("fwd_dist1", FWD_A_SEL, 2'b01);
    drain(); set_id(0, 0, 0, 0, 5, 1, 0); step(); set_id(0, 0, 0, 0, 0, 0, 0); step();
    set_id(5, 1, 0, 0, 0, 0, 0); @(negedge CLK); chk("fwd_dist2", FWD_A_SEL, 2'b10);
    drain(); set_id(0, 0, 0, 0, 5, 1, 0); step(); set_id(0, 0, 0, 0, 0, 0, 0); step(); step();
    set_id(5, 1, 0, 0, 0, 0, 0); @(negedge CLK); chk("fwd_dist3", FWD_A_SEL, 2'b00);
    drain(); set_id(0, 0, 0, 0, 0, 1, 0); step();
    set_id(0, 1, 0, 1, 0, 0, 0); @(negedge CLK); chk("fwd_x0", {FWD_A_SEL, FWD_B_SEL}, 4'b0000);

    // Load-use: one bubble, then forward from WB-bound load
    drain(); set_id(0, 0, 0, 0, 7, 1, 1); step();
    set_id(0, 0, 7, 1, 0, 0, 0); @(negedge CLK);
    chk("lu_stall", {STALL_F, STALL_D, STALL_E, FLUSH_D, FLUSH_E}, 5'b11001);
    step(); @(negedge CLK);
    chk("lu_after", {STALL_F, STALL_D, FLUSH_E}, 3'b000);
    chk("lu_fwd_b", FWD_B_SEL, 2'b10);

    // Redirect beats load-use and bubbles EX
    drain(); set_id(0, 0, 0, 0, 7, 1, 1); step();
    set_id(0, 0, 7, 1, 9, 1, 0); PC_SEL = 1; @(negedge CLK);
    chk("redirect", {STALL_F, STALL_D, FLUSH_D, FLUSH_E}, 4'b0011);
    step(); PC_SEL = 0; set_id(9, 1, 7, 1, 0, 0, 0); @(negedge CLK);
    chk("redir_bubble", {STALL_F, FWD_A_SEL, FWD_B_SEL}, 5'b00010);

    // Memory wait: 3 stalled cycles, release in the ready cycle, scoreboard frozen
    drain(); set_id(0, 0, 0, 0, 3, 1, 0); step();
    set_id(3, 1, 0, 0, 0, 0, 0); DMEM_REQ = 1; DMEM_READY = 0; cnt_st = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if ({STALL_F, STALL_D, STALL_E, STALL_M} == 4'b1111) cnt_st++;
      step();
    end
    chk("mw_stall_cycles", cnt_st, 3);
    DMEM_READY = 1; @(negedge CLK);
    chk("mw_release", {STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E}, 0);
    chk("mw_sb_held", FWD_A_SEL, 2'b01);
    step(); DMEM_REQ = 0; DMEM_READY = 0;

    // Timeout: MEM_ERR after TMO wait cycles beyond the entry cycle
    drain(); DMEM_REQ = 1; DMEM_READY = 0; n = 0;
    while (!MEM_ERR && n < 20) begin step(); n++; end
    chk("tmo_cycles", n, TMO + 1);
    DMEM_READY = 1; @(negedge CLK);
    chk("err_hold", {STALL_F, STALL_D, STALL_E, STALL_M, MEM_ERR}, 5'b11111);
    step(); step(); @(negedge CLK);
    chk("err_sticky", {STALL_F, STALL_M, MEM_ERR}, 3'b111);

    // Async reset out of ERR and out of a wait in progress
    step(); RST_N = 0; #1;
    chk("rst_async_err", {STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, FWD_A_SEL, FWD_B_SEL, MEM_ERR}, 0);
    step(); RST_N = 1; DMEM_READY = 0;
    repeat (3) step();
    RST_N = 0; #1;
    chk("rst_async_wait", {STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, FWD_A_SEL, FWD_B_SEL, MEM_ERR}, 0);
    step(); RST_N = 1; DMEM_REQ = 0; @(negedge CLK);
    chk("rst_back_run", {STALL_F, STALL_M, MEM_ERR}, 3'b000);

    // Randomized traffic; consecutive not-ready bounded to stay clear of the watchdog
    lows = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      set_id($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      PC_SEL   = ($urandom_range(0, 7) == 0);
      DMEM_REQ = ($urandom_range(0, 3) == 0);
      DMEM_READY = (lows >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
      lows = DMEM_READY ? 0 : lows + 1;
    end
    step();
    @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
